// File: rtl/gate_id_pkg.sv
// rtl/gate_id_pkg.sv - shared gate codes, truth-table constants and FSM states for gate identification
package gate_id_pkg;

  localparam logic [2:0] GATE_AND     = 3'd0;
  localparam logic [2:0] GATE_OR      = 3'd1;
  localparam logic [2:0] GATE_NAND    = 3'd2;
  localparam logic [2:0] GATE_NOR     = 3'd3;
  localparam logic [2:0] GATE_XOR     = 3'd4;
  localparam logic [2:0] GATE_XNOR    = 3'd5;
  localparam logic [2:0] GATE_UNKNOWN = 3'd7;

  // Bit i holds the gate output for inputs {a,b} = i.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

endpackage

// File: rtl/gate_tt_decoder.sv
// rtl/gate_tt_decoder.sv - combinational truth table to gate code classifier
module gate_tt_decoder
  import gate_id_pkg::*;
(
  input  logic [3:0] tt_i,
  output logic [2:0] gate_code_o,
  output logic       gate_valid_o
);

  always_comb begin
    gate_code_o  = GATE_UNKNOWN;
    gate_valid_o = 1'b1;
    case (tt_i)
      TT_AND:  gate_code_o = GATE_AND;
      TT_OR:   gate_code_o = GATE_OR;
      TT_NAND: gate_code_o = GATE_NAND;
      TT_NOR:  gate_code_o = GATE_NOR;
      TT_XOR:  gate_code_o = GATE_XOR;
      TT_XNOR: gate_code_o = GATE_XNOR;
      default: gate_valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_identifier.sv
// rtl/gate_identifier.sv - probes an external 2-input gate with all input pairs and classifies it
module gate_identifier
  import gate_id_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_y,
  output logic       probe_a,
  output logic       probe_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_table,
  output logic [2:0] gate_code,
  output logic       gate_valid
);

  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  // With no settle time each probe goes straight to sampling.
  localparam state_e AFTER_PROBE = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;

  state_e     state_q, state_d;
  logic [1:0] index_q, index_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] shadow_q, shadow_d;
  logic [1:0] probe_q, probe_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] tt_q, tt_d;
  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;

  logic [3:0] final_tt;
  logic [2:0] dec_code;
  logic       dec_valid;

  assign final_tt = {dut_y, shadow_q};

  gate_tt_decoder u_decoder (
    .tt_i        (final_tt),
    .gate_code_o (dec_code),
    .gate_valid_o(dec_valid)
  );

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    probe_d  = probe_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tt_d     = tt_q;
    code_d   = code_q;
    valid_d  = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = AFTER_PROBE;
          index_d  = 2'd0;
          probe_d  = 2'd0;
          cnt_d    = 4'd0;
          shadow_d = 3'd0;
          busy_d   = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (index_q != 2'd3) begin
          shadow_d[index_q] = dut_y;
          index_d = index_q + 2'd1;
          probe_d = index_q + 2'd1;
          cnt_d   = 4'd0;
          state_d = AFTER_PROBE;
        end else begin
          // Last vector: publish straight from the completed table so REPORT is a single cycle.
          tt_d    = final_tt;
          code_d  = dec_code;
          valid_d = dec_valid;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          probe_d = 2'd0;
          state_d = ST_REPORT;
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      index_q  <= 2'd0;
      cnt_q    <= 4'd0;
      shadow_q <= 3'd0;
      probe_q  <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tt_q     <= 4'b0000;
      code_q   <= GATE_UNKNOWN;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      probe_q  <= probe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tt_q     <= tt_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
    end
  end

  assign probe_a     = probe_q[1];
  assign probe_b     = probe_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign truth_table = tt_q;
  assign gate_code   = code_q;
  assign gate_valid  = valid_q;

endmodule

// File: tb/tb_gate_identifier.sv
// tb/tb_gate_identifier.sv - self-checking bench for gate_identifier at settle times 1, 0 and 15
module tb_gate_identifier;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_v [3];
  logic       y_v     [3];
  logic       pa      [3];
  logic       pb      [3];
  logic       bsy     [3];
  logic       dn      [3];
  logic       gv      [3];
  logic [3:0] tt_o    [3];
  logic [2:0] gc      [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gate_identifier #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .dut_y(y_v[0]),
    .probe_a(pa[0]), .probe_b(pb[0]), .busy(bsy[0]), .done(dn[0]),
    .truth_table(tt_o[0]), .gate_code(gc[0]), .gate_valid(gv[0])
  );

  gate_identifier #(.SETTLE_CYCLES(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .dut_y(y_v[1]),
    .probe_a(pa[1]), .probe_b(pb[1]), .busy(bsy[1]), .done(dn[1]),
    .truth_table(tt_o[1]), .gate_code(gc[1]), .gate_valid(gv[1])
  );

  gate_identifier #(.SETTLE_CYCLES(15)) u_s15 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .dut_y(y_v[2]),
    .probe_a(pa[2]), .probe_b(pb[2]), .busy(bsy[2]), .done(dn[2]),
    .truth_table(tt_o[2]), .gate_code(gc[2]), .gate_valid(gv[2])
  );

  // op: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 buffer of a, other constant 1
  function automatic logic [3:0] gate_table(input int op);
    logic [3:0] t;
    logic a, b;
    for (int i = 0; i < 4; i++) begin
      a = i[1];
      b = i[0];
      case (op)
        0: t[i] = a & b;
        1: t[i] = a | b;
        2: t[i] = ~(a & b);
        3: t[i] = ~(a | b);
        4: t[i] = a ^ b;
        5: t[i] = ~(a ^ b);
        6: t[i] = a;
        default: t[i] = 1'b1;
      endcase
    end
    return t;
  endfunction

  function automatic int ref_code(input logic [3:0] tbl);
    for (int op = 0; op < 6; op++) begin
      if (gate_table(op) == tbl) return op;
    end
    return 7;
  endfunction

  task automatic chk(input string tag, input int obs, input int want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  // Starts a run on instance sel at the current negedge and follows it cycle by cycle.
  task automatic run(input int sel, input int s, input logic [3:0] tbl, input bit glitch, input bit extra);
    int last, idx, code;
    bit smp;
    logic [3:0] old_tt;
    logic [2:0] old_gc;
    last   = 4 * (s + 1) + 1;
    code   = ref_code(tbl);
    old_tt = tt_o[sel];
    old_gc = gc[sel];
    start_v[sel] = 1'b1;
    y_v[sel]     = tbl[0];
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      start_v[sel] = extra && (k == 2 || k == last - 1 || k == last);
      idx = (k < last) ? (k - 1) / (s + 1) : 0;
      chk("busy", int'(bsy[sel]), int'(k < last));
      chk("done", int'(dn[sel]), int'(k == last));
      chk("probe", int'({pa[sel], pb[sel]}), idx);
      if (k < last) begin
        chk("tt_hold", int'(tt_o[sel]), int'(old_tt));
        chk("code_hold", int'(gc[sel]), int'(old_gc));
      end else begin
        chk("truth_table", int'(tt_o[sel]), int'(tbl));
        chk("gate_code", int'(gc[sel]), code);
        chk("gate_valid", int'(gv[sel]), int'(code != 7));
      end
      smp = (k < last) && (k % (s + 1) == 0);
      y_v[sel] = (glitch && !smp) ? 1'($urandom) : tbl[idx[1:0]];
    end
    start_v[sel] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      y_v[i]     = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_probe", int'({pa[i], pb[i]}), 0);
      chk("rst_busy", int'(bsy[i]), 0);
      chk("rst_done", int'(dn[i]), 0);
      chk("rst_tt", int'(tt_o[i]), 0);
      chk("rst_code", int'(gc[i]), 7);
      chk("rst_valid", int'(gv[i]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // All known gates plus buffer and constant-1; the first run carries ignored start pulses.
    for (int op = 0; op < 8; op++) begin
      run(0, 1, gate_table(op), 1'b0, op == 0);
    end

    // AND result held, then an XOR run aborted by reset at cycle 5.
    run(0, 1, gate_table(0), 1'b0, 1'b0);
    start_v[0] = 1'b1;
    y_v[0]     = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_probe", int'({pa[0], pb[0]}), 0);
    chk("abort_busy", int'(bsy[0]), 0);
    chk("abort_done", int'(dn[0]), 0);
    chk("abort_tt", int'(tt_o[0]), 0);
    chk("abort_code", int'(gc[0]), 7);
    chk("abort_valid", int'(gv[0]), 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", int'(dn[0]), 0);
      chk("abort_idle", int'(bsy[0]), 0);
    end
    run(0, 1, gate_table(4), 1'b1, 1'b0);

    repeat (8) run(0, 1, 4'($urandom), 1'b1, 1'b0);

    run(1, 0, gate_table(5), 1'b1, 1'b0);
    run(2, 15, gate_table(5), 1'b1, 1'b0);
    run(1, 0, 4'($urandom), 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
